// File: rtl/bus_interface_pkg.sv
// bus_interface_pkg: shared CPU bus types and constants
package bus_interface_pkg;
   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} bus_state_t;
   localparam logic [7:0] DL_ABORT = 8'hFF;
endpackage

// File: rtl/bus_timeout.sv
// bus_timeout: counts ACCESS cycles and flags the cycle in which the wait limit is reached
module bus_timeout #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic sys_clock,
   input  logic reset,
   input  logic i_active,
   output logic o_expired
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_count;
   assign o_expired = i_active && (r_count == CW'(TIMEOUT_CYCLES - 1));
   // count cycles spent in an access, restarting whenever the bus is idle
   always_ff @(posedge sys_clock) begin
      if (reset || !i_active) r_count <= '0;
      else if (!o_expired) r_count <= r_count + 1'b1;
   end
endmodule

// File: rtl/bus_interface.sv
// bus_interface: CPU-to-memory bridge with address/data registers and a req/ack handshake (optional WAIT_TIMEOUT_EN abort)
module bus_interface
   import bus_interface_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        sys_clock,
   input  logic        reset,
   input  logic        phase_1,
   input  logic        phase_2,
   input  logic        adl_abl,
   input  logic        adh_abh,
   input  logic [7:0]  address_l,
   input  logic [7:0]  address_h,
   input  logic        db_dor,
   input  logic        dl_db,
   input  logic        mem_cycle,
   input  logic        read_write,
   inout  wire  [7:0]  data_bus,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        mem_req,
   output logic        mem_we,
   input  logic        mem_ack,
   output logic        cpu_stall,
   output logic        bus_error
);
   bus_state_t r_state;
   logic [7:0] r_abl, r_abh, r_dor, r_dl;
   logic       r_mem_req, r_mem_we;
   assign mem_addr  = {r_abh, r_abl};
   assign mem_wdata = r_dor;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign cpu_stall = (r_state == ACCESS);
   assign data_bus  = dl_db ? r_dl : 8'bz;
`ifdef WAIT_TIMEOUT_EN
   logic w_expired;
   logic r_bus_error;
   assign bus_error = r_bus_error;
   bus_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .sys_clock (sys_clock),
      .reset     (reset),
      .i_active  (r_state == ACCESS),
      .o_expired (w_expired)
   );
`else
   assign bus_error = 1'b0;
`endif
   // bus FSM: latch CPU registers while idle, run the memory handshake while accessing
   always_ff @(posedge sys_clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_abl     <= '0;
         r_abh     <= '0;
         r_dor     <= '0;
         r_dl      <= '0;
         r_mem_req <= 1'b0;
         r_mem_we  <= 1'b0;
`ifdef WAIT_TIMEOUT_EN
         r_bus_error <= 1'b0;
`endif
      end else begin
`ifdef WAIT_TIMEOUT_EN
         r_bus_error <= 1'b0;
`endif
         if (r_state == IDLE) begin
            if (phase_2 && mem_cycle) begin
               r_state   <= ACCESS;
               r_mem_req <= 1'b1;
               r_mem_we  <= ~read_write;
            end else if (phase_1) begin
               if (adl_abl) r_abl <= address_l;
               if (adh_abh) r_abh <= address_h;
               if (db_dor)  r_dor <= data_bus;
            end
         end else if (mem_ack) begin
            if (!r_mem_we) r_dl <= mem_rdata;
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
`ifdef WAIT_TIMEOUT_EN
         end else if (w_expired) begin
            r_dl        <= DL_ABORT;
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_bus_error <= 1'b1;
`endif
         end
      end
   end
endmodule

// File: tb/tb_bus_interface.sv
// tb_bus_interface: directed self-checking bench for bus_interface
module tb_bus_interface;
   logic        sys_clock, reset, phase_1, phase_2, adl_abl, adh_abh, db_dor, dl_db;
   logic        mem_cycle, read_write, mem_ack, tb_db_en;
   logic [7:0]  address_l, address_h, mem_rdata, tb_db, mem_wdata;
   logic [15:0] mem_addr;
   logic        mem_req, mem_we, cpu_stall, bus_error;
   wire  [7:0]  data_bus;
   int          checks = 0;
   int          failures = 0;

   assign data_bus = tb_db_en ? tb_db : 8'bz;

   bus_interface #(.TIMEOUT_CYCLES(16)) dut (
      .sys_clock(sys_clock), .reset(reset), .phase_1(phase_1), .phase_2(phase_2),
      .adl_abl(adl_abl), .adh_abh(adh_abh), .address_l(address_l), .address_h(address_h),
      .db_dor(db_dor), .dl_db(dl_db), .mem_cycle(mem_cycle), .read_write(read_write),
      .data_bus(data_bus), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .cpu_stall(cpu_stall),
      .bus_error(bus_error)
   );

   initial sys_clock = 1'b0;
   always #5 sys_clock = ~sys_clock;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge sys_clock);
      #1;
   endtask

   task automatic chk_dl(input string tag, input logic [7:0] exp);
      tb_db_en = 1'b0;
      dl_db = 1'b1;
      #1;
      check(tag, {8'h00, data_bus}, {8'h00, exp});
      dl_db = 1'b0;
      #1;
   endtask

   task automatic start(input logic rw);
      read_write = rw;
      phase_2 = 1'b1;
      mem_cycle = 1'b1;
      step();
      phase_2 = 1'b0;
      mem_cycle = 1'b0;
   endtask

   initial begin
      reset = 1'b1; phase_1 = 0; phase_2 = 0; adl_abl = 0; adh_abh = 0; db_dor = 0; dl_db = 0;
      mem_cycle = 0; read_write = 1; mem_ack = 0; tb_db_en = 0; address_l = 0; address_h = 0;
      mem_rdata = 0; tb_db = 0;
      step(2);
      check("rst_req", {15'd0, mem_req}, 16'd0);
      check("rst_stall", {15'd0, cpu_stall}, 16'd0);
      check("rst_addr", mem_addr, 16'h0000);
      check("rst_wdata", {8'h00, mem_wdata}, 16'h0000);
      check("rst_berr", {15'd0, bus_error}, 16'd0);
      chk_dl("rst_dl", 8'h00);
      reset = 1'b0;

      phase_1 = 1; adl_abl = 1; adh_abh = 1; address_l = 8'h34; address_h = 8'h12;
      db_dor = 1; tb_db_en = 1; tb_db = 8'h5C;
      step();
      phase_1 = 0; adl_abl = 0; adh_abh = 0; db_dor = 0; tb_db_en = 0;
      check("load_addr", mem_addr, 16'h1234);
      check("load_dor", {8'h00, mem_wdata}, 16'h005C);

      start(1'b1);
      check("rd_stall1", {15'd0, cpu_stall}, 16'd1);
      check("rd_req", {15'd0, mem_req}, 16'd1);
      check("rd_we", {15'd0, mem_we}, 16'd0);
      phase_1 = 1; adl_abl = 1; adh_abh = 1; address_l = 8'h99; address_h = 8'h88;
      step();
      check("rd_stall2", {15'd0, cpu_stall}, 16'd1);
      check("acc_addr_hold", mem_addr, 16'h1234);
      step();
      check("rd_stall3", {15'd0, cpu_stall}, 16'd1);
      phase_1 = 0; adl_abl = 0; adh_abh = 0;
      mem_ack = 1; mem_rdata = 8'hA5;
      step();
      mem_ack = 0;
      check("rd_done_stall", {15'd0, cpu_stall}, 16'd0);
      check("rd_done_req", {15'd0, mem_req}, 16'd0);
      check("rd_addr_after", mem_addr, 16'h1234);
      chk_dl("rd_dl", 8'hA5);

      mem_ack = 1; mem_rdata = 8'h3C;
      step();
      mem_ack = 0;
      check("idle_ack_stall", {15'd0, cpu_stall}, 16'd0);
      chk_dl("idle_ack_dl", 8'hA5);

      start(1'b0);
      check("wr_req", {15'd0, mem_req}, 16'd1);
      check("wr_we", {15'd0, mem_we}, 16'd1);
      check("wr_wdata", {8'h00, mem_wdata}, 16'h005C);
      phase_2 = 1; mem_cycle = 1; read_write = 1;
      step();
      phase_2 = 0; mem_cycle = 0;
      check("wr_noop_we", {15'd0, mem_we}, 16'd1);
      check("wr_noop_stall", {15'd0, cpu_stall}, 16'd1);
      mem_ack = 1; mem_rdata = 8'h77;
      step();
      mem_ack = 0;
      check("wr_done_req", {15'd0, mem_req}, 16'd0);
      check("wr_done_we", {15'd0, mem_we}, 16'd0);
      chk_dl("wr_dl_keep", 8'hA5);
      step();
      check("no_queue_stall", {15'd0, cpu_stall}, 16'd0);

      start(1'b1);
      check("pre_rst_stall", {15'd0, cpu_stall}, 16'd1);
      reset = 1; mem_ack = 1; mem_rdata = 8'h11;
      step();
      reset = 0; mem_ack = 0;
      check("mid_rst_req", {15'd0, mem_req}, 16'd0);
      check("mid_rst_stall", {15'd0, cpu_stall}, 16'd0);
      check("mid_rst_addr", mem_addr, 16'h0000);
      check("mid_rst_wdata", {8'h00, mem_wdata}, 16'h0000);
      chk_dl("mid_rst_dl", 8'h00);

`ifdef WAIT_TIMEOUT_EN
      start(1'b1);
      step(15);
      check("to_stall15", {15'd0, cpu_stall}, 16'd1);
      check("to_berr15", {15'd0, bus_error}, 16'd0);
      step();
      check("to_stall16", {15'd0, cpu_stall}, 16'd0);
      check("to_berr16", {15'd0, bus_error}, 16'd1);
      check("to_req16", {15'd0, mem_req}, 16'd0);
      chk_dl("to_dl", 8'hFF);
      step();
      check("to_berr_pulse", {15'd0, bus_error}, 16'd0);
      start(1'b1);
      step(15);
      mem_ack = 1; mem_rdata = 8'h3C;
      step();
      mem_ack = 0;
      check("race_berr", {15'd0, bus_error}, 16'd0);
      check("race_stall", {15'd0, cpu_stall}, 16'd0);
      chk_dl("race_dl", 8'h3C);
`else
      start(1'b1);
      step(20);
      check("wait_stall", {15'd0, cpu_stall}, 16'd1);
      check("wait_berr", {15'd0, bus_error}, 16'd0);
      mem_ack = 1; mem_rdata = 8'h3C;
      step();
      mem_ack = 0;
      check("wait_done_stall", {15'd0, cpu_stall}, 16'd0);
      chk_dl("wait_dl", 8'h3C);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bus_interface.md
BUS_INTERFACE -- requirements
Module: bus_interface

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of ACCESS cycles without mem_ack before abort; used only with WAIT_TIMEOUT_EN.
REQ-002 SHALL have port sys_clock  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port phase_1  input  1  CPU phase-1 qualifier.
REQ-005 SHALL have port phase_2  input  1  CPU phase-2 qualifier.
REQ-006 SHALL have port adl_abl  input  1  load the low address register from address_l on phase_1.
REQ-007 SHALL have port adh_abh  input  1  load the high address register from address_h on phase_1.
REQ-008 SHALL have port address_l  input  8  internal low address bus.
REQ-009 SHALL have port address_h  input  8  internal high address bus.
REQ-010 SHALL have port db_dor  input  1  load the data output register from data_bus on phase_1.
REQ-011 SHALL have port dl_db  input  1  drive the data latch onto data_bus.
REQ-012 SHALL have port mem_cycle  input  1  start a memory access on phase_2.
REQ-013 SHALL have port read_write  input  1  1 = read, 0 = write; sampled at access start.
REQ-014 SHALL have port data_bus  inout  8  internal data bus; high-Z unless dl_db.
REQ-015 SHALL have port mem_addr  output  16  external address, {ABH,ABL}.
REQ-016 SHALL have port mem_wdata  output  8  data output register contents.
REQ-017 SHALL have port mem_rdata  input  8  external read data.
REQ-018 SHALL have port mem_req  output  1  registered access request.
REQ-019 SHALL have port mem_we  output  1  registered write strobe, valid while mem_req.
REQ-020 SHALL have port mem_ack  input  1  external completion.
REQ-021 SHALL have port cpu_stall  output  1  high while an access is outstanding.
REQ-022 SHALL have port bus_error  output  1  one-cycle abort pulse.

Function
REQ-023 SHALL implement a two-state FSM: IDLE and ACCESS.
REQ-024 SHALL load ABL/ABH from address_l/address_h, and DOR from data_bus, at phase_1 edges only while in IDLE; these loads are ignored in ACCESS.
REQ-025 SHALL, in IDLE at a phase_2 edge with mem_cycle=1, enter ACCESS, set mem_req=1, set mem_we=~read_write, and drop loads at the same edge.
REQ-026 SHALL hold mem_addr, mem_we and mem_wdata stable throughout ACCESS.
REQ-027 SHALL, in ACCESS at an edge with mem_ack=1: capture mem_rdata into DL if reading, return to IDLE, and clear mem_req and mem_we at that edge; minimum latency is request to DL valid in 1 cycle.
REQ-028 SHALL drive cpu_stall = (state==ACCESS) combinationally.
REQ-029 SHALL ignore mem_ack in IDLE.
REQ-030 SHALL leave DL unchanged on write accesses.
REQ-031 SHALL treat mem_cycle and phase_2 asserted during ACCESS as no-ops; no queuing.

Reset
REQ-032 SHALL, on reset, set state=IDLE, ABL=ABH=DL=DOR=0, mem_req=mem_we=0, bus_error=0, and timeout count=0.
REQ-033 SHALL have reset take priority over every other event, including reset asserted mid-ACCESS with mem_ack=1, in which case DL is not updated.

Configuration
REQ-034 SHALL, with macro WAIT_TIMEOUT_EN defined, count ACCESS cycles; when the count reaches TIMEOUT_CYCLES with no mem_ack, it SHALL abort to IDLE, load DL=8'hFF, and pulse bus_error for 1 cycle.
REQ-035 SHALL, when mem_ack arrives in the same cycle as the timeout, complete normally with no bus_error.
REQ-036 SHALL, without WAIT_TIMEOUT_EN, tie bus_error to 0, omit the counter, and wait for mem_ack indefinitely.

Structure
REQ-037 SHALL place the FSM state typedef (IDLE, ACCESS) and the DL abort constant 8'hFF in the shared CPU package.
REQ-038 SHALL implement the timeout counter as sub-module bus_timeout, instantiated only under WAIT_TIMEOUT_EN.

Verification
REQ-039 SHALL cover: phase_1 with adl_abl, adh_abh, address_l=34, address_h=12 -> mem_addr=16'h1234.
REQ-040 SHALL cover: read, mem_cycle on phase_2, mem_ack 3 cycles later with mem_rdata=A5 -> cpu_stall high 3 cycles, DL=A5, data_bus=A5 under dl_db.
REQ-041 SHALL cover: write with DOR=5C, read_write=0 -> mem_we=1, mem_wdata=5C while mem_req, DL unchanged.
REQ-042 SHALL cover: address loads during ACCESS -> mem_addr unchanged until IDLE.
REQ-043 SHALL cover: reset mid-ACCESS -> mem_req=0, cpu_stall=0 next cycle, all registers 0.
REQ-044 SHALL cover, with WAIT_TIMEOUT_EN: no ack for 16 cycles -> bus_error pulse, DL=FF, IDLE; ack on cycle 16 -> no bus_error.
